// File: rtl/psum_accumulator.sv
// psum_accumulator: K-pass accumulation of 16x16 psum tiles, int8 requant.
// Optional ACC_RELU_EN: clamp negative requant results to 0 before int8 sat.
module psum_accumulator #(
  parameter int LANES = 16,
  parameter int ROWS  = 16,
  parameter int IN_W  = 20,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [7:0]             num_tiles,
  input  logic [3:0]             shift,
  input  logic                   in_valid,
  input  logic [LANES*IN_W-1:0]  din,
  output logic                   busy,
  output logic                   out_valid,
  output logic [3:0]             out_row,
  output logic [LANES*OUT_W-1:0] dout,
  output logic                   done
);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             row_cnt_q, row_cnt_d;
  logic [7:0]             tile_cnt_q, tile_cnt_d;
  logic [7:0]             ntiles_q, ntiles_d;
  logic [3:0]             shift_q, shift_d;
  logic                   out_valid_q, out_valid_d;
  logic [3:0]             out_row_q, out_row_d;
  logic [LANES*OUT_W-1:0] dout_q, dout_d;
  logic                   done_q, done_d;

  logic                   accept;
  logic                   first_pass;
  logic                   last_pass;
  logic                   last_row;
  logic [LANES*OUT_W-1:0] req_row;

  assign accept     = (state_q == ACCUM) && in_valid;
  assign first_pass = (tile_cnt_q == 8'd0);
  assign last_pass  = (tile_cnt_q == ntiles_q - 8'd1);
  assign last_row   = (row_cnt_q == 4'(ROWS - 1));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [ACC_W-1:0]         mem [ROWS];
    logic signed [IN_W-1:0]   x;
    logic signed [ACC_W-1:0]  old;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W:0]    wide;
    logic signed [ACC_W+1:0]  ext;
    logic signed [ACC_W+1:0]  bias;
    logic signed [ACC_W+1:0]  rnd;
    logic [ACC_W-OUT_W+2:0]   hi;
    logic [OUT_W-1:0]         q;

    assign x   = din[(LANES-1-g)*IN_W +: IN_W];
    assign old = mem[row_cnt_q];

    // Saturating accumulate; the first pass overwrites stale RAM contents.
    always_comb begin
      wide = {old[ACC_W-1], old}
           + {{(ACC_W+1-IN_W){x[IN_W-1]}}, x};
      sum  = wide[ACC_W-1:0];
      if (wide[ACC_W] != wide[ACC_W-1]) begin
        sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                          : {1'b0, {(ACC_W-1){1'b1}}};
      end
      if (first_pass) begin
        sum = {{(ACC_W-IN_W){x[IN_W-1]}}, x};
      end
    end

    // Round half up, arithmetic shift, optional relu, clamp to int8.
    always_comb begin
      ext  = {{2{sum[ACC_W-1]}}, sum};
      bias = '0;
      if (shift_q != 4'd0) begin
        bias[shift_q - 4'd1] = 1'b1;
      end
      rnd = (ext + bias) >>> shift_q;
`ifdef ACC_RELU_EN
      if (rnd[ACC_W+1]) begin
        rnd = '0;
      end
`endif
      hi = rnd[ACC_W+1:OUT_W-1];
      q  = rnd[OUT_W-1:0];
      if (!(&hi) && (|hi)) begin
        q = rnd[ACC_W+1] ? {1'b1, {(OUT_W-1){1'b0}}}
                         : {1'b0, {(OUT_W-1){1'b1}}};
      end
    end

    assign req_row[(LANES-1-g)*OUT_W +: OUT_W] = q;

    // Accumulator RAM; deliberately unreset, pass 0 overwrites it.
    always_ff @(posedge clk) begin
      if (accept) begin
        mem[row_cnt_q] <= sum;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      tile_cnt_q  <= '0;
      ntiles_q    <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      dout_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      tile_cnt_q  <= tile_cnt_d;
      ntiles_q    <= ntiles_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      dout_q      <= dout_d;
      done_q      <= done_d;
    end
  end

  // Job sequencing: row/tile counters and final-pass emission.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    tile_cnt_d  = tile_cnt_q;
    ntiles_d    = ntiles_q;
    shift_d     = shift_q;
    out_valid_d = 1'b0;
    out_row_d   = out_row_q;
    dout_d      = dout_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ACCUM;
          ntiles_d   = (num_tiles == 8'd0) ? 8'd1 : num_tiles;
          shift_d    = shift;
          row_cnt_d  = '0;
          tile_cnt_d = '0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          row_cnt_d = row_cnt_q + 4'd1;
          if (last_row) begin
            row_cnt_d  = '0;
            tile_cnt_d = tile_cnt_q + 8'd1;
            if (last_pass) begin
              state_d = IDLE;
            end
          end
          if (last_pass) begin
            out_valid_d = 1'b1;
            out_row_d   = row_cnt_q;
            dout_d      = req_row;
            done_d      = last_row;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign dout      = dout_q;
  assign done      = done_q;

endmodule
